// File: rtl/event_time_normalizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | event_time_normalizer: DVS event grid/time quantizer, fixed 2-cycle lat.  |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module event_time_normalizer #(
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int T_W      = 32,
  parameter int XY_SHIFT = 2,
  parameter int T_SHIFT  = 10,
  parameter int TQ_W     = 8,
  parameter int WINDOW   = 300000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [X_W-1:0]       i_x,
  input  logic [Y_W-1:0]       i_y,
  input  logic [T_W-1:0]       i_t,
  input  logic                 i_p,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [X_W-XY_SHIFT-1:0] o_x,
  output logic [Y_W-XY_SHIFT-1:0] o_y,
  output logic [TQ_W-1:0]      o_t,
  output logic                 o_p,
  output logic                 o_win_start,
  output logic [15:0]          o_drop_cnt
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [T_W-1:0] c_window = T_W'(WINDOW);
  localparam logic [T_W-1:0] c_tq_max = {{(T_W-TQ_W){1'b0}}, {TQ_W{1'b1}}};

  state_t         r_state;
  logic [T_W-1:0] r_t_ref;
  logic [T_W-1:0] r_t_last;

  logic           r_s1_valid;
  logic [X_W-1:0] r_s1_x;
  logic [Y_W-1:0] r_s1_y;
  logic           r_s1_p;
  logic [T_W-1:0] r_s1_rel;
  logic           r_s1_win;

  logic           w_idle;
  logic [T_W-1:0] w_d_last;
  logic [T_W-1:0] w_d_ref;
  logic           w_back;
  logic           w_new_win;
  logic           w_accept;
  logic           w_drop;
  logic           w_open;
  logic [T_W-1:0] w_rel_sh;
  logic [TQ_W-1:0] w_tq;

  // A flush makes the same-edge event behave as the first event after idle.
  assign w_idle    = (r_state == IDLE) || i_flush;
  assign w_d_last  = i_t - r_t_last;
  assign w_d_ref   = i_t - r_t_ref;
  assign w_back    = w_d_last[T_W-1];
  assign w_new_win = (w_d_ref >= c_window);
  assign w_accept  = i_valid && (w_idle || !w_back);
  assign w_drop    = i_valid && !w_idle && w_back;
  assign w_open    = w_idle || w_new_win;

  assign w_rel_sh = r_s1_rel >> T_SHIFT;
  assign w_tq     = (w_rel_sh > c_tq_max) ? {TQ_W{1'b1}} : w_rel_sh[TQ_W-1:0];

  // Stage 1: classification, reference-time tracking and drop accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_t_ref    <= '0;
      r_t_last   <= '0;
      o_drop_cnt <= '0;
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_p     <= 1'b0;
      r_s1_rel   <= '0;
      r_s1_win   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_state  <= ACTIVE;
        r_t_last <= i_t;
        r_s1_x   <= i_x;
        r_s1_y   <= i_y;
        r_s1_p   <= i_p;
        r_s1_win <= w_open;
        if (w_open) begin
          r_t_ref  <= i_t;
          r_s1_rel <= '0;
        end else begin
          r_s1_rel <= w_d_ref;
        end
      end else if (i_flush) begin
        r_state <= IDLE;
      end
      if (w_drop && (o_drop_cnt != 16'hFFFF)) begin
        o_drop_cnt <= o_drop_cnt + 16'd1;
      end
    end
  end

  // Stage 2: coordinate/time quantization; data holds while no event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_x         <= '0;
      o_y         <= '0;
      o_t         <= '0;
      o_p         <= 1'b0;
      o_win_start <= 1'b0;
    end else begin
      o_valid     <= r_s1_valid;
      o_win_start <= r_s1_valid && r_s1_win;
      if (r_s1_valid) begin
        o_x <= r_s1_x[X_W-1:XY_SHIFT];
        o_y <= r_s1_y[Y_W-1:XY_SHIFT];
        o_t <= w_tq;
        o_p <= r_s1_p;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_event_time_normalizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_event_time_normalizer: directed self-checking bench                    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_event_time_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [7:0]  i_x;
  logic [7:0]  i_y;
  logic [31:0] i_t;
  logic        i_p;
  logic        i_flush;
  logic        o_valid;
  logic [5:0]  o_x;
  logic [5:0]  o_y;
  logic [7:0]  o_t;
  logic        o_p;
  logic        o_win_start;
  logic [15:0] o_drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  event_time_normalizer dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_x         (i_x),
    .i_y         (i_y),
    .i_t         (i_t),
    .i_p         (i_p),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .o_x         (o_x),
    .o_y         (o_y),
    .o_t         (o_t),
    .o_p         (o_p),
    .o_win_start (o_win_start),
    .o_drop_cnt  (o_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one input cycle, then move to just after the sampling edge.
  task automatic step(input logic v, input logic [7:0] x, input logic [7:0] y,
                      input logic [31:0] t, input logic p, input logic f);
    i_valid = v; i_x = x; i_y = y; i_t = t; i_p = p; i_flush = f;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 8'd0, 8'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // One event followed by one idle cycle: outputs then hold that event.
  task automatic ev(input logic [31:0] t, input logic f);
    step(1'b1, 8'd40, 8'd80, t, 1'b0, f);
    idle();
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_x = '0; i_y = '0; i_t = '0; i_p = 1'b0; i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_x", 32'(o_x), 32'd0);
    chk("rst_t", 32'(o_t), 32'd0);
    chk("rst_win", 32'(o_win_start), 32'd0);
    chk("rst_drop", 32'(o_drop_cnt), 32'd0);
    rst = 1'b0;
    idle();

    // First event opens a window
    step(1'b1, 8'd13, 8'd200, 32'd1000, 1'b1, 1'b0);
    chk("lat_not_early", 32'(o_valid), 32'd0);
    idle();
    chk("e1_valid", 32'(o_valid), 32'd1);
    chk("e1_x", 32'(o_x), 32'd3);
    chk("e1_y", 32'(o_y), 32'd50);
    chk("e1_t", 32'(o_t), 32'd0);
    chk("e1_win", 32'(o_win_start), 32'd1);
    chk("e1_p", 32'(o_p), 32'd1);
    idle();
    chk("hold_valid", 32'(o_valid), 32'd0);
    chk("hold_win", 32'(o_win_start), 32'd0);
    chk("hold_x", 32'(o_x), 32'd3);

    ev(32'd6120, 1'b0);
    chk("rel5_t", 32'(o_t), 32'd5);
    chk("rel5_win", 32'(o_win_start), 32'd0);
    ev(32'd271000, 1'b0);
    chk("sat_t", 32'(o_t), 32'd255);
    chk("sat_valid", 32'(o_valid), 32'd1);
    ev(32'd301000, 1'b0);
    chk("newwin_win", 32'(o_win_start), 32'd1);
    chk("newwin_t", 32'(o_t), 32'd0);

    // Backward events
    ev(32'd5000, 1'b1);
    chk("fl5000_win", 32'(o_win_start), 32'd1);
    ev(32'd4000, 1'b0);
    chk("back_valid", 32'(o_valid), 32'd0);
    chk("back_drop", 32'(o_drop_cnt), 32'd1);
    ev(32'd5000, 1'b0);
    chk("eq_valid", 32'(o_valid), 32'd1);
    chk("eq_win", 32'(o_win_start), 32'd0);
    chk("eq_t", 32'(o_t), 32'd0);
    i_valid = 1'b1; i_t = 32'd4000;
    repeat (65536) @(posedge clk);
    #1;
    i_valid = 1'b0;
    idle();
    chk("drop_sat", 32'(o_drop_cnt), 32'h0000FFFF);
    chk("drop_noout", 32'(o_valid), 32'd0);

    // Timestamp wrap
    ev(32'hFFFFFF00, 1'b1);
    chk("wrap_ref_win", 32'(o_win_start), 32'd1);
    ev(32'h00000100, 1'b0);
    chk("wrap_valid", 32'(o_valid), 32'd1);
    chk("wrap_t", 32'(o_t), 32'd0);
    chk("wrap_win", 32'(o_win_start), 32'd0);

    // Back-to-back burst, first event flushed in at t=9000
    for (int i = 0; i < 7; i++) begin
      i_valid = (i < 5);
      i_x = 8'(16 * i + 4);
      i_y = 8'(8 * i);
      i_t = 32'(9000 + 2048 * i);
      i_p = 1'b0;
      i_flush = (i == 0);
      @(posedge clk); #1;
      i_flush = 1'b0;
      if (i >= 1 && i <= 5) begin
        chk($sformatf("burst%0d_valid", i - 1), 32'(o_valid), 32'd1);
        chk($sformatf("burst%0d_x", i - 1), 32'(o_x), 32'(4 * (i - 1) + 1));
        chk($sformatf("burst%0d_y", i - 1), 32'(o_y), 32'(2 * (i - 1)));
        chk($sformatf("burst%0d_t", i - 1), 32'(o_t), 32'(2 * (i - 1)));
        chk($sformatf("burst%0d_win", i - 1), 32'(o_win_start), (i == 1) ? 32'd1 : 32'd0);
      end else if (i == 6) begin
        chk("burst_end_valid", 32'(o_valid), 32'd0);
      end
    end
    i_valid = 1'b0;

    // Flush without event returns to idle: an older timestamp then opens a window
    step(1'b0, 8'd0, 8'd0, 32'd0, 1'b0, 1'b1);
    ev(32'd1000, 1'b0);
    chk("flidle_valid", 32'(o_valid), 32'd1);
    chk("flidle_win", 32'(o_win_start), 32'd1);
    chk("flidle_drop", 32'(o_drop_cnt), 32'h0000FFFF);

    // Asynchronous reset with two events in flight
    step(1'b1, 8'd100, 8'd100, 32'd2000, 1'b1, 1'b0);
    i_valid = 1'b1; i_x = 8'd120; i_t = 32'd3000;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_x", 32'(o_x), 32'd0);
    chk("arst_drop", 32'(o_drop_cnt), 32'd0);
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("arst_quiet%0d", i), 32'(o_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
